// File: rtl/vr74x74_pkg.sv
// -----------------------------------------------------------------------------
// vr74x74_pkg
// Shared definitions for the 74x74 D flip-flop checker:
//   - state_t      : checker FSM states (IDLE, RUN, FAIL, DONE)
//   - EXP_*        : forced expected {Q,QN} pairs for the asynchronous controls
//   - CNT_W_DEF    : default width of the check/error counters
//   - exp_pair_f() : expected {Q,QN} for one sampling edge
// -----------------------------------------------------------------------------
package vr74x74_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Expected {Q,QN} while the asynchronous controls are active.
   // With both controls low a real 74x74 drives both outputs high.
   localparam logic [1:0] EXP_PRESET = 2'b10;
   localparam logic [1:0] EXP_CLEAR  = 2'b01;
   localparam logic [1:0] EXP_BOTH   = 2'b11;

   // Expected {Q,QN} at an edge. Controls sampled at this edge dominate;
   // otherwise the outputs show the value captured on the previous edge.
   function automatic logic [1:0] exp_pair_f(input logic pr_l,
                                             input logic clr_l,
                                             input logic exp_q);
      logic [1:0] pair;
      case ({pr_l, clr_l})
         2'b00:   pair = EXP_BOTH;
         2'b01:   pair = EXP_PRESET;
         2'b10:   pair = EXP_CLEAR;
         default: pair = {exp_q, ~exp_q};
      endcase
      return pair;
   endfunction

endpackage

// File: rtl/vr74x74_ref_model.sv
// -----------------------------------------------------------------------------
// vr74x74_ref_model
// Cycle-accurate expected model of a 74x74 D flip-flop. Tracks the stimulus
// on every rising edge regardless of the checker state, so a run can start at
// any time with a valid prediction.
//
// Ports:
//   CLK          in   system clock, rising-edge sampling
//   RST_L        in   asynchronous active-low reset
//   i_d          in   data stimulus
//   i_pr_l       in   preset stimulus, active-low
//   i_clr_l      in   clear stimulus, active-low
//   o_exp_pair   out  expected {Q,QN} for the current edge
//   o_cmp_en     out  1 when the expected pair is defined at this edge
// -----------------------------------------------------------------------------
module vr74x74_ref_model
   import vr74x74_pkg::*;
(
   input  logic       CLK,
   input  logic       RST_L,
   input  logic       i_d,
   input  logic       i_pr_l,
   input  logic       i_clr_l,
   output logic [1:0] o_exp_pair,
   output logic       o_cmp_en
);

   logic r_exp_q;
   logic r_exp_valid;
   logic w_forced;

   // NOTE: state registers use non-blocking assignments so every flop in the
   // design samples the pre-edge values, exactly like the hardware.
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         r_exp_q     <= 1'b0;
         r_exp_valid <= 1'b0;
      end else begin
         case ({i_pr_l, i_clr_l})
            // Releasing both controls together leaves the real part in an
            // unpredictable state, so the next stored value is not trusted.
            2'b00: begin
               r_exp_q     <= 1'b1;
               r_exp_valid <= 1'b0;
            end
            2'b01: begin
               r_exp_q     <= 1'b1;
               r_exp_valid <= 1'b1;
            end
            2'b10: begin
               r_exp_q     <= 1'b0;
               r_exp_valid <= 1'b1;
            end
            default: begin
               r_exp_q     <= i_d;
               r_exp_valid <= 1'b1;
            end
         endcase
      end
   end

   assign w_forced   = ~i_pr_l | ~i_clr_l;
   assign o_exp_pair = exp_pair_f(i_pr_l, i_clr_l, r_exp_q);
   // A forced pair is always known; a clocked pair only if the stored
   // value came from a well-defined edge.
   assign o_cmp_en   = w_forced | r_exp_valid;

endmodule

// File: rtl/vr74x74_checker.sv
// -----------------------------------------------------------------------------
// vr74x74_checker
// Self-checking monitor for a 74x74 D flip-flop. Watches the stimulus and the
// DUT response on the shared clock, compares against an expected model while
// running, and reports counts plus a pass/fail verdict.
//
// Parameters:
//   CNT_W        width of CHK_CNT / ERR_CNT / FIRST_ERR
//   MAX_CHECKS   compares after which the run ends in DONE (0 = unlimited)
//   STOP_ON_ERR  1 = enter FAIL on the first mismatch, 0 = keep counting
//
// Ports:
//   CLK, RST_L          clock, asynchronous active-low reset
//   START, STOP         one-cycle run control pulses
//   D, PR_L, CLR_L      stimulus applied to the DUT
//   Q, QN               DUT response
//   BUSY, DONE, PASS    status decoded from the FSM state
//   ERR                 sticky first-mismatch flag for the current run
//   CHK_CNT             compares performed in this run
//   ERR_CNT             mismatches, saturating
//   FIRST_ERR           CHK_CNT value at the first mismatch
// -----------------------------------------------------------------------------
module vr74x74_checker
   import vr74x74_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int MAX_CHECKS  = 0,
   parameter int STOP_ON_ERR = 1
) (
   input  logic             CLK,
   input  logic             RST_L,
   input  logic             START,
   input  logic             STOP,
   input  logic             D,
   input  logic             PR_L,
   input  logic             CLR_L,
   input  logic             Q,
   input  logic             QN,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic             ERR,
   output logic [CNT_W-1:0] CHK_CNT,
   output logic [CNT_W-1:0] ERR_CNT,
   output logic [CNT_W-1:0] FIRST_ERR
);

   localparam logic [CNT_W-1:0] MAX_CHK = CNT_W'(MAX_CHECKS);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_chk_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [CNT_W-1:0] r_first_err;
   logic             r_err;

   logic [1:0]       w_exp_pair;
   logic             w_cmp_en;
   logic             w_cmp;
   logic             w_mis;
   logic             w_max_hit;
   logic             w_run_entry;
   logic [CNT_W-1:0] w_chk_inc;

   vr74x74_ref_model u_ref_model (
      .CLK        (CLK),
      .RST_L      (RST_L),
      .i_d        (D),
      .i_pr_l     (PR_L),
      .i_clr_l    (CLR_L),
      .o_exp_pair (w_exp_pair),
      .o_cmp_en   (w_cmp_en)
   );

   assign w_cmp       = (r_state == ST_RUN) && w_cmp_en;
   assign w_mis       = w_cmp && ({Q, QN} != w_exp_pair);
   assign w_chk_inc   = r_chk_cnt + 1'b1;
   // The run ends on the edge of the final compare, not one edge later.
   assign w_max_hit   = (MAX_CHECKS != 0) && w_cmp && (w_chk_inc == MAX_CHK);
   // START is ignored inside RUN; from any other state it opens a new run.
   assign w_run_entry = START && (r_state != ST_RUN);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: the next state gets a default before the case so that no path
   // through this block leaves it unassigned, which would infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (START) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // A mismatch outranks STOP and the check limit when stopping on
            // errors; otherwise the run still ends on STOP or the limit.
            if (w_mis && (STOP_ON_ERR != 0))  w_state_nxt = ST_FAIL;
            else if (STOP || w_max_hit)       w_state_nxt = ST_DONE;
         end
         ST_FAIL, ST_DONE: begin
            if (START) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- counters
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         r_chk_cnt   <= '0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
         r_err       <= 1'b0;
      end else if (w_run_entry) begin
         r_chk_cnt   <= '0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
         r_err       <= 1'b0;
      end else if (w_cmp) begin
         r_chk_cnt <= w_chk_inc;
         if (w_mis) begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            // FIRST_ERR records the pre-increment count: the index of the
            // failing compare counted from zero.
            if (!r_err) begin
               r_first_err <= r_chk_cnt;
               r_err       <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------ outputs
   assign BUSY      = (r_state == ST_RUN);
   assign DONE      = (r_state == ST_DONE);
   assign PASS      = (r_state == ST_DONE) && (r_err_cnt == '0);
   assign ERR       = r_err;
   assign CHK_CNT   = r_chk_cnt;
   assign ERR_CNT   = r_err_cnt;
   assign FIRST_ERR = r_first_err;

endmodule

// File: tb/tb_vr74x74_checker.sv
// -----------------------------------------------------------------------------
// tb_vr74x74_checker
// Directed bench for vr74x74_checker. Instance A uses the defaults
// (STOP_ON_ERR=1, unlimited checks); instance B uses STOP_ON_ERR=0 and
// MAX_CHECKS=8. Both share the stimulus and DUT response lines; each has its
// own START/STOP. Q/QN are hand-driven to the value a correct (or faulty)
// flip-flop would show at each edge.
// -----------------------------------------------------------------------------
module tb_vr74x74_checker;

   localparam int CNT_W = 16;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RST_L;
   logic START_A, STOP_A, START_B, STOP_B;
   logic D, PR_L, CLR_L, Q, QN;

   logic             a_busy, a_done, a_pass, a_err;
   logic [CNT_W-1:0] a_chk, a_ecnt, a_first;
   logic             b_busy, b_done, b_pass, b_err;
   logic [CNT_W-1:0] b_chk, b_ecnt, b_first;

   int checks = 0;
   int errors = 0;

   vr74x74_checker #(.CNT_W(CNT_W), .MAX_CHECKS(0), .STOP_ON_ERR(1)) dut_a (
      .CLK(CLK), .RST_L(RST_L), .START(START_A), .STOP(STOP_A),
      .D(D), .PR_L(PR_L), .CLR_L(CLR_L), .Q(Q), .QN(QN),
      .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .ERR(a_err),
      .CHK_CNT(a_chk), .ERR_CNT(a_ecnt), .FIRST_ERR(a_first)
   );

   vr74x74_checker #(.CNT_W(CNT_W), .MAX_CHECKS(8), .STOP_ON_ERR(0)) dut_b (
      .CLK(CLK), .RST_L(RST_L), .START(START_B), .STOP(STOP_B),
      .D(D), .PR_L(PR_L), .CLR_L(CLR_L), .Q(Q), .QN(QN),
      .BUSY(b_busy), .DONE(b_done), .PASS(b_pass), .ERR(b_err),
      .CHK_CNT(b_chk), .ERR_CNT(b_ecnt), .FIRST_ERR(b_first)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one vector at the falling edge, let the rising edge sample it,
   // and return 1 time unit later for checking.
   task automatic step(input logic st_a, input logic sp_a,
                       input logic st_b, input logic sp_b,
                       input logic d, input logic pr, input logic clr,
                       input logic q, input logic qn);
      @(negedge CLK);
      START_A = st_a; STOP_A = sp_a; START_B = st_b; STOP_B = sp_b;
      D = d; PR_L = pr; CLR_L = clr; Q = q; QN = qn;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST_L = 1'b0;
      START_A = 1'b0; STOP_A = 1'b0; START_B = 1'b0; STOP_B = 1'b0;
      D = 1'b0; PR_L = 1'b1; CLR_L = 1'b1; Q = 1'b0; QN = 1'b1;

      // ---- reset state
      #12;
      check("rst_a_busy",  a_busy, 0);
      check("rst_a_done",  a_done, 0);
      check("rst_a_pass",  a_pass, 0);
      check("rst_a_err",   a_err,  0);
      check("rst_a_chk",   a_chk,  0);
      check("rst_b_ecnt",  b_ecnt, 0);
      RST_L = 1'b1;

      // ---- correct DUT, D = 0,1,1,0 (Q shows the previous capture)
      step(1,0,0,0, 0,1,1, 0,1);          // START edge, no compare
      check("start_busy", a_busy, 1);
      check("start_chk",  a_chk,  0);
      step(0,0,0,0, 0,1,1, 0,1);
      step(0,0,0,0, 1,1,1, 0,1);
      step(0,0,0,0, 1,1,1, 1,0);
      step(0,0,0,0, 0,1,1, 1,0);
      check("toggle_chk",  a_chk,  4);
      check("toggle_ecnt", a_ecnt, 0);
      step(0,1,0,0, 0,1,1, 0,1);          // STOP edge still compares
      check("stop_done", a_done, 1);
      check("stop_pass", a_pass, 1);
      check("stop_busy", a_busy, 0);
      check("stop_chk",  a_chk,  5);

      // ---- preset, then release with D=0
      step(1,0,0,0, 0,1,1, 0,1);          // restart from DONE
      check("restart_chk",  a_chk,  0);
      check("restart_done", a_done, 0);
      step(0,0,0,0, 0,0,1, 1,0);          // PR_L low: forced (1,0)
      step(0,0,0,0, 0,1,1, 1,0);          // released: still (1,0)
      step(0,0,0,0, 0,1,1, 0,1);          // now (0,1)
      check("preset_chk", a_chk, 3);
      check("preset_err", a_err, 0);
      step(1,0,0,0, 1,1,1, 0,1);          // START inside RUN ignored
      check("start_in_run_chk",  a_chk,  4);
      check("start_in_run_busy", a_busy, 1);

      // ---- injected mismatch on compare #3, stop-on-error
      step(0,1,0,0, 1,1,1, 1,0);          // STOP -> DONE
      step(1,0,0,0, 1,1,1, 1,0);          // new run
      step(0,0,0,0, 0,1,1, 1,0);          // cmp 1 ok
      step(0,0,0,0, 1,1,1, 0,1);          // cmp 2 ok
      step(0,0,0,0, 1,1,1, 0,1);          // cmp 3: expected (1,0)
      check("fail_busy",  a_busy,  0);
      check("fail_done",  a_done,  0);
      check("fail_err",   a_err,   1);
      check("fail_first", a_first, 2);
      check("fail_ecnt",  a_ecnt,  1);
      check("fail_chk",   a_chk,   3);
      step(0,0,0,0, 1,1,1, 0,1);          // FAIL holds counters
      check("fail_hold_chk",  a_chk,  3);
      check("fail_hold_ecnt", a_ecnt, 1);

      // ---- both controls low, then release: next edge not compared
      step(1,0,0,0, 0,1,1, 1,0);          // restart from FAIL
      check("refail_err",   a_err,   0);
      check("refail_first", a_first, 0);
      check("refail_ecnt",  a_ecnt,  0);
      step(0,0,0,0, 0,0,0, 1,1);          // forced (1,1)
      step(0,0,0,0, 0,1,1, 0,1);          // exp_valid = 0: skipped
      check("both_skip_chk", a_chk, 1);
      step(0,0,0,0, 1,1,0, 0,1);          // CLR_L low: forced (0,1)
      check("clear_chk", a_chk, 2);
      check("clear_err", a_err, 0);

      // ---- reset mid-run, between edges
      #2 RST_L = 1'b0;
      #1;
      check("midrst_busy", a_busy, 0);
      check("midrst_chk",  a_chk,  0);
      check("midrst_done", a_done, 0);
      RST_L = 1'b1;
      step(1,0,0,0, 0,1,1, 0,1);          // fresh run
      step(0,0,0,0, 1,1,1, 0,1);          // cmp 1 ok (exp 0)
      check("fresh_busy", a_busy, 1);
      check("fresh_chk",  a_chk,  1);
      check("fresh_ecnt", a_ecnt, 0);

      // ---- instance B: no stop on error, 8-check limit, 3 mismatches
      step(0,1,1,0, 0,1,1, 1,0);          // A stops, B starts
      check("b_start_busy", b_busy, 1);
      step(0,0,0,0, 0,1,1, 0,1);          // cmp 1 ok
      step(0,0,0,0, 0,1,1, 1,0);          // cmp 2 bad
      check("b_err_busy",  b_busy,  1);
      check("b_err_first", b_first, 1);
      step(0,0,0,0, 0,1,1, 0,1);          // cmp 3
      step(0,0,0,0, 0,1,1, 0,1);          // cmp 4
      step(0,0,0,0, 0,1,1, 1,0);          // cmp 5 bad
      step(0,0,0,0, 0,1,1, 0,1);          // cmp 6
      step(0,0,0,0, 0,1,1, 1,0);          // cmp 7 bad
      check("b_cmp7_ecnt", b_ecnt, 3);
      check("b_cmp7_busy", b_busy, 1);
      step(0,0,0,0, 0,1,1, 0,1);          // cmp 8 -> DONE
      check("b_max_done", b_done, 1);
      check("b_max_chk",  b_chk,  8);
      check("b_max_ecnt", b_ecnt, 3);
      check("b_max_pass", b_pass, 0);
      check("b_max_busy", b_busy, 0);
      step(0,0,0,0, 0,1,1, 1,0);          // DONE holds
      check("b_hold_chk",  b_chk,  8);
      check("b_hold_ecnt", b_ecnt, 3);

      // ---- STOP and mismatch on the same edge (STOP_ON_ERR = 0)
      step(0,0,1,0, 0,1,1, 0,1);
      check("b_restart_chk", b_chk, 0);
      step(0,0,0,1, 0,1,1, 1,1);
      check("b_stopmis_done", b_done, 1);
      check("b_stopmis_chk",  b_chk,  1);
      check("b_stopmis_ecnt", b_ecnt, 1);
      check("b_stopmis_pass", b_pass, 0);
      check("b_stopmis_err",  b_err,  1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
